// File: rtl/dual_fetch_queue_if.sv
// Issue, fetch-control and instruction-memory bus of the dual fetch queue.
// master = fetch unit, slave = HCU / branch unit / instruction memory.
interface dual_fetch_queue_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          fetch_next;
    logic          redirect_in;
    logic [7:0]    redirect_pc_in;
    logic [7:0]    im_addr0;
    logic [7:0]    im_addr1;
    logic          im_req;
    logic [15:0]   im_rdata0;
    logic [15:0]   im_rdata1;
    logic [15:0]   p0_IR_out;
    logic [7:0]    p0_PC_out;
    logic [15:0]   p1_IR_out;
    logic [7:0]    p1_PC_out;
    logic          p0_valid_out;
    logic          p1_valid_out;
    logic [CW-1:0] q_count_out;

    modport master (
        input  fetch_next, redirect_in, redirect_pc_in,
        input  im_rdata0, im_rdata1,
        output im_addr0, im_addr1, im_req,
        output p0_IR_out, p0_PC_out, p1_IR_out, p1_PC_out,
        output p0_valid_out, p1_valid_out, q_count_out
    );

    modport slave (
        output fetch_next, redirect_in, redirect_pc_in,
        output im_rdata0, im_rdata1,
        input  im_addr0, im_addr1, im_req,
        input  p0_IR_out, p0_PC_out, p1_IR_out, p1_PC_out,
        input  p0_valid_out, p1_valid_out, q_count_out
    );
endinterface

// File: rtl/dual_fetch_queue.sv
// Dual-issue fetch unit: two-word IM fetches into a circular {PC, IR}
// queue, oldest two entries presented as the p0/p1 issue pair.
module dual_fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter logic [15:0] NOP_INST = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    dual_fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    fetch_pc;
    logic [7:0]    req_pc;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic          inflight;

    logic [7:0]    pc_q [DEPTH];
    logic [15:0]   ir_q [DEPTH];

    logic          req;
    logic          push;
    logic [CW-1:0] pop_n;
    logic [CW:0]   need;
    logic [AW-1:0] head1;
    logic [AW-1:0] tail1;

    // Request, push and pop decisions for this cycle
    always_comb begin
        need  = {1'b0, count} + (inflight ? (CW+1)'(2) : '0);
        req   = rst && !bus.redirect_in && (need <= (CW+1)'(DEPTH - 2));
        push  = inflight && !bus.redirect_in;
        pop_n = '0;
        if (bus.fetch_next)
            pop_n = (count >= CW'(2)) ? CW'(2) : count;
        head1 = head + AW'(1);
        tail1 = tail + AW'(1);
    end

    // Pointers, occupancy and fetch PC; redirect overrides everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else if (bus.redirect_in) begin
            fetch_pc <= bus.redirect_pc_in;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            head     <= head + pop_n[AW-1:0];
            tail     <= push ? tail + AW'(2) : tail;
            count    <= count + (push ? CW'(2) : '0) - pop_n;
            inflight <= req;
            if (req) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 8'd2;
            end
        end
    end

    // Queue storage; the returning pair lands at tail and tail+1
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[tail]  <= req_pc;
            ir_q[tail]  <= bus.im_rdata0;
            pc_q[tail1] <= req_pc + 8'd1;
            ir_q[tail1] <= bus.im_rdata1;
        end
    end

    // Issue pair and IM request, combinational from registered state
    always_comb begin
        bus.p0_IR_out    = NOP_INST;
        bus.p0_PC_out    = '0;
        bus.p0_valid_out = 1'b0;
        bus.p1_IR_out    = NOP_INST;
        bus.p1_PC_out    = '0;
        bus.p1_valid_out = 1'b0;
        if (count >= CW'(2)) begin
            bus.p0_IR_out    = ir_q[head];
            bus.p0_PC_out    = pc_q[head];
            bus.p0_valid_out = 1'b1;
            bus.p1_IR_out    = ir_q[head1];
            bus.p1_PC_out    = pc_q[head1];
            bus.p1_valid_out = 1'b1;
        end else if (count == CW'(1)) begin
            bus.p0_IR_out    = ir_q[head];
            bus.p0_PC_out    = pc_q[head];
            bus.p0_valid_out = 1'b1;
            bus.p1_PC_out    = pc_q[head] + 8'd1;
        end
        bus.im_req      = req;
        bus.im_addr0    = fetch_pc;
        bus.im_addr1    = fetch_pc + 8'd1;
        bus.q_count_out = count;
    end
endmodule

// File: tb/tb_dual_fetch_queue.sv
// Randomized bench for dual_fetch_queue against a queue-based model,
// plus literal checks for start-up, stall, redirect, wrap and reset.
module tb_dual_fetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dual_fetch_queue_if #(.DEPTH(8)) bus ();
    dual_fetch_queue_if #(.DEPTH(8)) wbus ();

    dual_fetch_queue #(.DEPTH(8)) u_dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );

    dual_fetch_queue #(.DEPTH(8), .RESET_PC(8'hFE)) u_wrap (
        .clk(clk), .rst(rst), .bus(wbus.master)
    );

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] ir;
    } ent_t;

    ent_t        q[$];
    logic [7:0]  m_fpc;
    bit          m_infl;
    logic [7:0]  m_ipc;
    bit          m_req;
    logic [15:0] mem [256];

    bit          d_req;
    logic [7:0]  d_a0, d_a1, w_a0, w_a1;
    int          errors = 0;
    int          checks = 0;
    int          cyc;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h",
                     nm, cyc, act, exp);
        end
    endtask

    function automatic logic [49:0] exp_issue();
        logic [7:0] p1pc;
        if (q.size() >= 2)
            return {1'b1, q[0].pc, q[0].ir, 1'b1, q[1].pc, q[1].ir};
        if (q.size() == 1) begin
            p1pc = q[0].pc + 8'd1;
            return {1'b1, q[0].pc, q[0].ir, 1'b0, p1pc, 16'h0000};
        end
        return 50'd0;
    endfunction

    function automatic logic [49:0] act_issue();
        return {bus.p0_valid_out, bus.p0_PC_out, bus.p0_IR_out,
                bus.p1_valid_out, bus.p1_PC_out, bus.p1_IR_out};
    endfunction

    task automatic model_reset();
        q.delete();
        m_fpc  = 8'h00;
        m_infl = 0;
        m_ipc  = 8'h00;
    endtask

    // Negedge: compare DUT against model, capture IM addresses
    task automatic sample();
        logic [7:0] a1;
        @(negedge clk);
        m_req = rst && !bus.redirect_in &&
                (q.size() + 2 * int'(m_infl) <= 6);
        a1 = m_fpc + 8'd1;
        check("issue", 64'(act_issue()), 64'(exp_issue()));
        check("count", 64'(bus.q_count_out), 64'(q.size()));
        check("req", 64'(bus.im_req), 64'(m_req));
        if (m_req)
            check("addr", {48'd0, bus.im_addr0, bus.im_addr1},
                  {48'd0, m_fpc, a1});
        d_req = bus.im_req;
        d_a0  = bus.im_addr0;
        d_a1  = bus.im_addr1;
        w_a0  = wbus.im_addr0;
        w_a1  = wbus.im_addr1;
    endtask

    // Model step, then the clock edge and IM responses
    task automatic advance();
        ent_t e;
        if (rst) begin
            if (bus.redirect_in) begin
                q.delete();
                m_fpc  = bus.redirect_pc_in;
                m_infl = 0;
            end else begin
                if (bus.fetch_next)
                    for (int k = 0; k < 2; k++)
                        if (q.size() > 0) void'(q.pop_front());
                if (m_infl) begin
                    e.pc = m_ipc;
                    e.ir = mem[m_ipc];
                    q.push_back(e);
                    e.pc = m_ipc + 8'd1;
                    e.ir = mem[e.pc];
                    q.push_back(e);
                end
                m_infl = m_req;
                if (m_req) begin
                    m_ipc = m_fpc;
                    m_fpc = m_fpc + 8'd2;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (d_req) begin
            bus.im_rdata0 = mem[d_a0];
            bus.im_rdata1 = mem[d_a1];
        end else begin
            bus.im_rdata0 = 16'($urandom);
            bus.im_rdata1 = 16'($urandom);
        end
        wbus.im_rdata0 = 16'h1000 + 16'(w_a0);
        wbus.im_rdata1 = 16'h1000 + 16'(w_a1);
    endtask

    task automatic release_and_check_start();
        rst = 1'b1;
        bus.fetch_next  = 1'b1;
        bus.redirect_in = 1'b0;
        for (int c = 0; c < 6; c++) begin
            sample();
            if (c == 1)
                check("start_empty", 64'(bus.p0_valid_out), 64'd0);
            if (c == 2) begin
                check("c2_p0", {40'd0, bus.p0_PC_out, bus.p0_IR_out},
                      {40'd0, 8'h00, 16'h1000});
                check("c2_p1", {40'd0, bus.p1_PC_out, bus.p1_IR_out},
                      {40'd0, 8'h01, 16'h1001});
                check("wrap_c2", {32'd0, wbus.p0_PC_out, wbus.p1_PC_out,
                      wbus.p0_IR_out}, {32'd0, 8'hFE, 8'hFF, 16'h10FE});
            end
            if (c == 3) begin
                check("c3_p0", {40'd0, bus.p0_PC_out, bus.p0_IR_out},
                      {40'd0, 8'h02, 16'h1002});
                check("wrap_c3", {32'd0, wbus.p0_PC_out, wbus.p1_PC_out,
                      wbus.p1_IR_out}, {32'd0, 8'h00, 8'h01, 16'h1001});
            end
            if (c == 4)
                check("c4_p1", {48'd0, bus.p1_PC_out, 7'd0,
                      bus.p1_valid_out}, {48'd0, 8'h05, 8'h01});
            advance();
        end
    endtask

    initial begin
        cyc = 0;
        for (int i = 0; i < 256; i++)
            mem[i] = (i < 128) ? 16'h1000 + 16'(i) : 16'($urandom);
        bus.fetch_next     = 1'b0;
        bus.redirect_in    = 1'b0;
        bus.redirect_pc_in = 8'h00;
        bus.im_rdata0      = 16'h0;
        bus.im_rdata1      = 16'h0;
        wbus.fetch_next     = 1'b1;
        wbus.redirect_in    = 1'b0;
        wbus.redirect_pc_in = 8'h00;
        wbus.im_rdata0      = 16'h0;
        wbus.im_rdata1      = 16'h0;
        model_reset();

        for (int c = 0; c < 2; c++) begin
            sample();
            advance();
        end
        cyc = 0;
        release_and_check_start();

        // Stall: queue fills to DEPTH and fetching stops
        bus.fetch_next = 1'b0;
        for (int c = 0; c < 10; c++) begin
            sample();
            advance();
        end
        sample();
        check("stall_full", {56'd0, bus.q_count_out, 3'd0, bus.im_req},
              {56'd0, 4'd8, 3'd0, 1'b0});
        advance();
        bus.fetch_next = 1'b1;
        for (int c = 0; c < 6; c++) begin
            sample();
            advance();
        end

        // Redirect to 8'h40 with a request in flight
        bus.redirect_in    = 1'b1;
        bus.redirect_pc_in = 8'h40;
        sample();
        advance();
        bus.redirect_in = 1'b0;
        bus.fetch_next  = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            sample();
            if (c == 1)
                check("redir_flush", {62'd0, bus.p0_valid_out,
                      bus.p1_valid_out}, 64'd0);
            if (c == 3)
                check("redir40", {32'd0, bus.p0_PC_out, bus.p1_PC_out,
                      bus.p1_IR_out}, {32'd0, 8'h40, 8'h41, 16'h1041});
            advance();
        end

        // Random traffic with occasional redirects
        for (int c = 0; c < 3000; c++) begin
            bus.fetch_next     = ($urandom_range(0, 3) != 0);
            bus.redirect_in    = ($urandom_range(0, 24) == 0);
            bus.redirect_pc_in = 8'($urandom);
            sample();
            advance();
        end
        bus.redirect_in = 1'b0;

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b0;
        #1;
        check("arst_out", {14'd0, act_issue()}, 64'd0);
        check("arst_cnt", {56'd0, bus.q_count_out, 3'd0, bus.im_req},
              64'd0);
        check("arst_wrap", {62'd0, wbus.p0_valid_out, wbus.p1_valid_out},
              64'd0);
        model_reset();
        sample();
        advance();
        cyc = 0;
        release_and_check_start();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
